// File: rtl/div_sched.sv
// rtl/div_sched.sv - EX-stage sequencer for the shared multi-cycle divider (optional result cache: DIV_SCHED_CACHE_EN)
module div_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mod,
  input  logic        req_signed,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        div_en,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  output logic        div_signed,
  input  logic [63:0] div_res,
  input  logic        div_res_valid,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy,
  output logic        div_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mod_q;
  logic [31:0]      res_q;
  logic             accept;
  logic             cnt_hit;
  logic             cache_hit;
  logic             timeout_evt;
  logic             complete;
  logic             cache_inval;

  // A request is only taken in IDLE and never in a flush cycle.
  assign accept      = (state == S_IDLE) & req_valid & ~flush;
  // The wait budget counts from the first cycle after div_en, across WAIT and DRAIN.
  assign cnt_hit     = (cnt == CNT_W'(TIMEOUT - 1));
  assign complete    = (state == S_WAIT) & div_res_valid & ~flush;
  assign cache_inval = flush | timeout_evt;
  assign resp_result = res_q;

`ifdef DIV_SCHED_CACHE_EN
  logic        c_valid;
  logic [31:0] c_src1;
  logic [31:0] c_src2;
  logic        c_signed;
  logic [63:0] c_res;

  assign cache_hit = c_valid & (c_src1 == req_src1) & (c_src2 == req_src2)
                   & (c_signed == req_signed);

  // Remember the last completed operation so a DIV/MOD pair on the same operands runs once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_valid  <= 1'b0;
      c_src1   <= '0;
      c_src2   <= '0;
      c_signed <= 1'b0;
      c_res    <= '0;
    end else if (cache_inval) begin
      c_valid <= 1'b0;
    end else if (complete) begin
      c_valid  <= 1'b1;
      c_src1   <= div_src1;
      c_src2   <= div_src2;
      c_signed <= div_signed;
      c_res    <= div_res;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs; a result arriving together with flush is simply dropped.
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    div_en      = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    timeout_evt = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) begin
          state_nx = cache_hit ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_en   = 1'b1;
        state_nx = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (div_res_valid) begin
          state_nx = flush ? S_IDLE : S_DONE;
        end else if (cnt_hit) begin
          timeout_evt = 1'b1;
          state_nx    = S_IDLE;
        end else if (flush) begin
          state_nx = S_DRAIN;
        end
      end
      S_DONE: begin
        resp_valid = ~flush;
        if (flush || resp_ready) begin
          state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (div_res_valid) begin
          state_nx = S_IDLE;
        end else if (cnt_hit) begin
          timeout_evt = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Operand capture, wait counter, result selection and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_src1    <= '0;
      div_src2    <= '0;
      div_signed  <= 1'b0;
      mod_q       <= 1'b0;
      res_q       <= '0;
      cnt         <= '0;
      div_timeout <= 1'b0;
    end else begin
      if (accept) begin
        div_src1   <= req_src1;
        div_src2   <= req_src2;
        div_signed <= req_signed;
        mod_q      <= req_mod;
      end
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT || state == S_DRAIN) begin
        cnt <= cnt + 1'b1;
      end
      if (complete) begin
        res_q <= mod_q ? div_res[31:0] : div_res[63:32];
      end
`ifdef DIV_SCHED_CACHE_EN
      else if (accept && cache_hit) begin
        res_q <= req_mod ? c_res[31:0] : c_res[63:32];
      end
`endif
      if (timeout_evt) begin
        div_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - scoreboard bench for div_sched with a behavioural divider and reference model
module tb_div_sched;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mod = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        flush = 1'b0;
  logic        div_en;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_signed;
  logic [63:0] div_res;
  logic        div_res_valid;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        busy;
  logic        div_timeout;

  div_sched #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mod(req_mod), .req_signed(req_signed), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .div_en(div_en), .div_src1(div_src1), .div_src2(div_src2),
    .div_signed(div_signed), .div_res(div_res), .div_res_valid(div_res_valid),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .busy(busy), .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          lat = 3;
  bit          no_resp = 1'b0;
  int          en_cnt = 0;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic        d_s;
  int          rem = 0;
  bit          dbusy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Divider semantics: truncating division, x/0 gives q=all ones r=x, signed overflow gives q=x r=0.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    int          sa;
    int          sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] expect_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input logic m);
    logic [63:0] r;
    r = div_ref(a, b, s);
    return m ? r[31:0] : r[63:32];
  endfunction

  // Behavioural divider: answers lat cycles after div_en, or never when no_resp is set.
  initial begin
    div_res_valid = 1'b0;
    div_res = '0;
    forever begin
      @(negedge clk);
      div_res_valid = 1'b0;
      if (!reset) begin
        dbusy = 1'b0;
        rem = 0;
      end else begin
        if (dbusy) begin
          rem--;
          if (rem == 0) begin
            dbusy = 1'b0;
            div_res_valid = 1'b1;
            div_res = div_ref(d_a, d_b, d_s);
            check("div_src1_hold", 64'(div_src1), 64'(d_a));
            check("div_src2_hold", 64'(div_src2), 64'(d_b));
          end
        end
        if (div_en) begin
          en_cnt++;
          check("no_restart_while_busy", 64'(dbusy), 64'd0);
          if (!no_resp) begin
            dbusy = 1'b1;
            rem = lat;
            d_a = div_src1;
            d_b = div_src2;
            d_s = div_signed;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every accepted response must match the oldest expected result.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: actual %0h required no response", resp_result);
        end else begin
          e = exp_q.pop_front();
          check("resp_result", 64'(resp_result), 64'(e));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int c;
    c = 0;
    while (!req_ready && c < 300) begin
      step();
      c++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual req_ready 0 required 1 within 300 cycles", name);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic m, input bit push);
    wait_ready("issue_wait");
    req_src1 = a;
    req_src2 = b;
    req_signed = s;
    req_mod = m;
    req_valid = 1'b1;
    if (push) exp_q.push_back(expect_res(a, b, s, m));
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int          c;
    int          e0;
    bit          hs;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    // Reset state
    step();
    step();
    reset = 1'b1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_timeout", 64'(div_timeout), 64'd0);
    check("rst_resp_result", 64'(resp_result), 64'd0);
    check("rst_div_src1", 64'(div_src1), 64'd0);

    // Signed DIV -7 / 2
    lat = 4;
    resp_ready = 1'b1;
    e0 = en_cnt;
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b1);
    check("t2_div_en_issue", 64'(div_en), 64'd1);
    c = 0;
    while (!resp_valid && c < 300) begin
      check("t2_busy", 64'(busy), 64'd1);
      step();
      c++;
    end
    check("t2_latency", 64'(c), 64'(1 + 4));
    check("t2_busy_done", 64'(busy), 64'd1);
    step();
    check("t2_idle_ready", 64'(req_ready), 64'd1);
    check("t2_idle_busy", 64'(busy), 64'd0);
    check("t2_en_pulses", 64'(en_cnt - e0), 64'd1);

    // Unsigned MOD 100 % 7 with a stalled consumer
    lat = 3;
    resp_ready = 1'b0;
    issue(32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
    c = 0;
    while (!resp_valid && c < 300) begin
      step();
      c++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(resp_valid), 64'd1);
      check("t3_hold_result", 64'(resp_result), 64'd2);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("t3_idle_after", 64'(req_ready), 64'd1);
    check("t3_valid_drop", 64'(resp_valid), 64'd0);

    // Flush in WAIT, then a fresh request
    lat = 8;
    issue(32'd55, 32'd5, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_drain_busy", 64'(busy), 64'd1);
    check("t4_drain_ready", 64'(req_ready), 64'd0);
    c = 0;
    while (!div_res_valid && c < 300) begin
      check("t4_no_resp", 64'(resp_valid), 64'd0);
      step();
      c++;
    end
    check("t4_ready_after_done", 64'(req_ready), 64'd1);
    e0 = en_cnt;
    lat = 2;
    issue(32'd7, 32'd3, 1'b0, 1'b0, 1'b1);
    check("t4_fresh_div_en", 64'(div_en), 64'd1);
    wait_ready("t4_finish");
    check("t4_fresh_pulses", 64'(en_cnt - e0), 64'd1);

    // Timeout with a silent divider
    no_resp = 1'b1;
    issue(32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
    c = 0;
    while (!div_timeout && c < 300) begin
      step();
      c++;
    end
    check("t5_timeout_cycles", 64'(c), 64'(TIMEOUT + 1));
    check("t5_idle", 64'(req_ready), 64'd1);
    no_resp = 1'b0;
    lat = 2;
    issue(32'd40, 32'd6, 1'b0, 1'b1, 1'b1);
    wait_ready("t5_after");
    check("t5_sticky", 64'(div_timeout), 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t5_cleared", 64'(div_timeout), 64'd0);

    // Reset in WAIT
    lat = 10;
    issue(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    check("t6_req_ready", 64'(req_ready), 64'd1);
    check("t6_resp_valid", 64'(resp_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_timeout", 64'(div_timeout), 64'd0);
    reset = 1'b1;
    step();

    // DIV then MOD on the same operands
    lat = 5;
    resp_ready = 1'b1;
    issue(32'h64, 32'h7, 1'b1, 1'b0, 1'b1);
    step();
    wait_ready("t7_first");
    e0 = en_cnt;
    issue(32'h64, 32'h7, 1'b1, 1'b1, 1'b1);
`ifdef DIV_SCHED_CACHE_EN
    check("t7_hit_valid", 64'(resp_valid), 64'd1);
    check("t7_hit_no_en", 64'(div_en), 64'd0);
    step();
    check("t7_hit_pulses", 64'(en_cnt - e0), 64'd0);
`else
    check("t7_miss_div_en", 64'(div_en), 64'd1);
    step();
    wait_ready("t7_second");
    check("t7_miss_pulses", 64'(en_cnt - e0), 64'd1);
`endif

    // Randomized operations with a randomly stalling consumer
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(1, 6);
      sel = $urandom_range(0, 7);
      a = $urandom();
      b = $urandom();
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (sel == 2) b = 32'($urandom_range(1, 9));
      issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      hs = 1'b0;
      c = 0;
      while (!hs && c < 400) begin
        resp_ready = 1'($urandom_range(0, 1));
        hs = resp_valid && resp_ready;
        step();
        c++;
      end
      if (!hs) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_handshake: actual none required response within 400 cycles");
      end
    end
    resp_ready = 1'b1;
    step();
    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
